// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store initiator: request sizes,
// FSM states and the default data memory depth.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    localparam int DEFAULT_MEM_WORDS = 512;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4
    } state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane logic: extracts and extends a load lane from a memory
// word, and merges store data into the addressed lane(s) of an old word.
module byte_lane_merge
    import mem_access_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [31:0] shifted;

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: begin
                shamt     = {(BIG_ENDIAN ? ~offset : offset), 3'b000};
                lane_mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                // Only offsets 0 and 2 reach here; the half sits in the upper
                // 16 bits for BE offset 0 or LE offset 2.
                shamt     = {offset[1] ^ BIG_ENDIAN, 4'b0000};
                lane_mask = 32'h0000_FFFF;
            end
            default: begin
                shamt     = 5'd0;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase

        shifted = mem_word >> shamt;

        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_data = mem_word;
        endcase

        merged = (mem_word & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-addressed, level-sensitive data
// memory; sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS  = DEFAULT_MEM_WORDS,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Addr,
    output logic [31:0] Wdata,
    input  logic [31:0] Rdata
);

    state_t      state, state_next;
    logic [1:0]  lat_size;
    logic [1:0]  lat_offset;
    logic        lat_signed;
    logic [31:0] lat_wdata;

    logic        accept, bad_req;
    logic        rsp_valid_next, rsp_err_next;
    logic [31:0] rsp_rdata_next, addr_next, wdata_next;
    logic [31:0] load_data, merged;

    assign accept  = req_valid && req_ready;
    assign bad_req = (req_size == SZ_ILLEGAL)
                  || (req_size == SZ_HALF && req_addr[0])
                  || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                  || ((req_addr >> 2) >= 32'(MEM_WORDS));

    byte_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .mem_word  (Rdata),
        .wdata     (lat_wdata),
        .offset    (lat_offset),
        .size      (lat_size),
        .sign_ext  (lat_signed),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_next     = state;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = 32'd0;
        addr_next      = Addr;
        wdata_next     = Wdata;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_req) begin
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                    end else begin
                        addr_next = req_addr >> 2;
                        if (!req_we) begin
                            state_next = ST_RD;
                        end else if (req_size == SZ_WORD) begin
                            state_next = ST_WR;
                            wdata_next = req_wdata;
                        end else begin
                            state_next = ST_RMW_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                state_next     = ST_IDLE;
                rsp_valid_next = 1'b1;
                rsp_rdata_next = load_data;
            end
            ST_RMW_RD: begin
                // Old word is merged straight off Rdata while MemRead holds it.
                state_next = ST_RMW_WR;
                wdata_next = merged;
            end
            ST_WR, ST_RMW_WR: begin
                state_next     = ST_IDLE;
                rsp_valid_next = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'd0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            Addr       <= 32'd0;
            Wdata      <= 32'd0;
            lat_size   <= SZ_BYTE;
            lat_offset <= 2'b00;
            lat_signed <= 1'b0;
            lat_wdata  <= 32'd0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == ST_IDLE);
            MemRead   <= (state_next == ST_RD) || (state_next == ST_RMW_RD);
            MemWrite  <= (state_next == ST_WR) || (state_next == ST_RMW_WR);
            rsp_valid <= rsp_valid_next;
            rsp_err   <= rsp_err_next;
            rsp_rdata <= rsp_rdata_next;
            Addr      <= addr_next;
            Wdata     <= wdata_next;
            if (accept) begin
                lat_size   <= req_size;
                lat_offset <= req_addr[1:0];
                lat_signed <= req_signed;
                lat_wdata  <= req_wdata;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store initiator that drives the word-addressed data memory (`DATAMEM`: `MemWrite`, `MemRead`, `Addr`, `Wdata`, `Rdata`) on behalf of the pipeline. It accepts one byte, half or word request at a time over a valid/ready handshake. It performs sub-word stores as read-modify-write and returns sign- or zero-extended load data with a one-cycle response pulse. While busy it holds off the pipeline via `req_ready`.

## Interface
- `MEM_WORDS`, 512: memory depth in 32-bit words; word indices at or above this are out of range.
- `BIG_ENDIAN`, 1: byte offset 0 maps to bits [31:24]; 0 maps it to bits [7:0].
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_signed` in 1: sign-extend a sub-word load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified for sub-word.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned, illegal size, or out-of-range; valid with `rsp_valid`.
- `MemRead` out 1: memory read enable.
- `MemWrite` out 1: memory write enable.
- `Addr` out 32: word index, `req_addr >> 2`.
- `Wdata` out 32: memory write word.
- `Rdata` in 32: memory read word; combinational from `Addr` and `MemRead`.

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR.
- A request is accepted on an edge where `req_valid && req_ready`. The unit latches addr, size, signed, we and wdata.
- Error check at accept: half with `addr[0]`, word with `addr[1:0]` non-zero, size 3, or word index ≥ `MEM_WORDS`.
  - On error: no memory access; stay in IDLE; `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0` next cycle.
- Load (any size): IDLE→RD→IDLE.
  - In RD, `MemRead=1`.
  - `Rdata` is captured at the RD→IDLE edge. The selected lane is extracted and extended (sign if `req_signed`, else zero) into `rsp_rdata`.
- Word store: IDLE→WR→IDLE. In WR, `MemWrite=1` and `Wdata=req_wdata`.
- Byte/half store: IDLE→RMW_RD→RMW_WR→IDLE.
  - RMW_RD reads the old word, which is captured at the edge.
  - RMW_WR writes the old word with only the addressed lane(s) replaced.
- `rsp_valid` pulses for one cycle, in the first IDLE cycle after completion.
- `req_ready` is high in that same cycle, so back-to-back accept is allowed.
- Requests presented while not ready are ignored. The requester must hold them until accepted.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- `Addr` and `Wdata` change only on the edge entering RD/WR/RMW_RD/RMW_WR, or on the RMW_RD→RMW_WR edge (`Wdata` only). They hold otherwise. The level-sensitive memory must never see an address or data change while `MemWrite=1`.
- `MemRead` and `MemWrite` are never high in the same cycle. Both are 0 in IDLE.
- Latency from accept edge to `rsp_valid` cycle:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
- Reset values: state IDLE; `req_ready=1`; `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`; `MemRead=0`, `MemWrite=0`, `Addr=0`, `Wdata=0`.
- Reset mid-operation: at the reset edge, `MemWrite`/`MemRead` drop and the state goes to IDLE. No response is issued. An RMW aborted in RMW_RD produces no write.
- `rst` and `req_valid` in the same cycle: reset wins and no accept occurs.

## Structure
- Package `mem_access_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state encoding constants;
  - default `MEM_WORDS`.
- Sub-module `byte_lane_merge` (combinational) contains:
  - lane extract with sign/zero extension for loads;
  - lane merge of old word and new data for stores.
  - `BIG_ENDIAN` is passed down to it.

## Test plan
- Word store then load, big-endian: store `0xDEADBEEF` @ `0x10` → `Addr=4`, `MemWrite` high for exactly 1 cycle; load word @ `0x10` → `rsp_rdata=0xDEADBEEF`, `rsp_valid` 2 cycles after accept.
- Sub-word RMW: word `0x11223344` @ `0x20`; store byte `0xAA` @ `0x21` → memory `0x11AA3344`, latency 3; load byte signed @ `0x21` → `0xFFFFFFAA`; unsigned → `0x000000AA`.
- Half load @ `0x22` on `0x11AA3344`, signed → `0x00003344`; `BIG_ENDIAN=0` run: half @ `0x22` → `0x000011AA`.
- Errors: half @ `0x03`, word @ `0x06`, size 3, word @ `0x800` → each gives `rsp_err=1` 1 cycle after accept; `MemRead`/`MemWrite` never assert.
- Back-to-back: `req_valid` held high with 4 requests → accept on every `rsp_valid` cycle; `req_ready` low while busy; memory enables never overlap.
- Reset in RMW_RD during byte store → no `MemWrite` pulse, memory word unchanged, `rsp_valid` stays 0, `req_ready=1` the cycle after reset.
